// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state encoding and one-hot decode helper for scan_decoder
package decoder_pkg;
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: free-running dwell counter that ticks when it matches the live dwell value
module dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
);
    logic [DWELL_W-1:0] count;
    assign tick = count == dwell;
    always_ff @(posedge clk)
        if (rst || clr) count <= '0;
        else count <= tick ? '0 : count + DWELL_W'(1);
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered binary-to-one-hot decoder with select handshake and timed scan mode
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int DWELL_W = 8,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               sel_valid,
    output logic               sel_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   y,
    output logic [SEL_W-1:0]   y_idx,
    output logic               wrap
);
    state_t state;
    logic tick;
    logic clr;
    logic [SEL_W-1:0] next_idx;
    assign next_idx = y_idx + SEL_W'(1);
    assign clr = !en || !mode || state != SCAN;
    dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .dwell(dwell),
        .tick(tick)
    );
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state     <= IDLE;
            y         <= '0;
            y_idx     <= '0;
            wrap      <= 1'b0;
            sel_ready <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    state     <= mode ? SCAN : DIRECT;
                    sel_ready <= !mode;
                    y         <= OUT_W'(mode);
                    y_idx     <= '0;
                end
                DIRECT: begin
                    if (mode) begin
                        state     <= SCAN;
                        sel_ready <= 1'b0;
                        y         <= OUT_W'(onehot(MAX_SEL_W'(y_idx)));
                    end else if (sel_valid && sel_ready) begin
                        y     <= OUT_W'(onehot(MAX_SEL_W'(sel)));
                        y_idx <= sel;
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        state     <= DIRECT;
                        sel_ready <= 1'b1;
                    end else if (tick) begin
                        y     <= OUT_W'(onehot(MAX_SEL_W'(next_idx)));
                        y_idx <= next_idx;
                        wrap  <= &y_idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: table-driven directed checks of scan_decoder plus multi-cycle scan corner cases
module tb_scan_decoder;
    logic       clk = 1'b0;
    logic       rst, en, mode, sel_valid, sel_ready, wrap;
    logic [1:0] sel, y_idx;
    logic [7:0] dwell;
    logic [3:0] y;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(2), .DWELL_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mode(mode),
        .sel_valid(sel_valid),
        .sel_ready(sel_ready),
        .sel(sel),
        .dwell(dwell),
        .y(y),
        .y_idx(y_idx),
        .wrap(wrap)
    );

    typedef struct {
        logic       r, e, m, v;
        logic [1:0] s;
        logic [7:0] d;
        logic [3:0] ey;
        logic [1:0] ei;
        logic       ew, er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic m, logic v, logic [1:0] s, logic [7:0] d,
                                logic [3:0] ey, logic [1:0] ei, logic ew, logic er);
        vec_t t;
        t.r = r; t.e = e; t.m = m; t.v = v; t.s = s; t.d = d;
        t.ey = ey; t.ei = ei; t.ew = ew; t.er = er;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        compared++;
        if ($countones(y) > 1) begin
            mismatched++;
            $display("FAIL onehot: y=%b has more than one bit set", y);
        end
    endtask

    task automatic check(string name, int act, int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = 2'd0; dwell = 8'd0;
        //             r  e  m  v  sel   dwell  y        idx   w  rdy
        vecs.push_back(mk(1, 0, 0, 0, 2'd0, 8'd0, 4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 2'd0, 8'd0, 4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2'd0, 8'd0, 4'b0000, 2'd0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 2'd3, 8'd0, 4'b1000, 2'd3, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 2'd2, 8'd0, 4'b0100, 2'd2, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 2'd0, 8'd0, 4'b0001, 2'd0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 2'd1, 8'd0, 4'b0010, 2'd1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2'd3, 8'd0, 4'b0010, 2'd1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2'd3, 8'd0, 4'b0010, 2'd1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'd0, 8'd2, 4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0010, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0010, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0010, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0100, 2'd2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0100, 2'd2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0100, 2'd2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b1000, 2'd3, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b1000, 2'd3, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b1000, 2'd3, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 4'b0010, 2'd1, 0, 0));
        // dwell 0 with a valid select that must be ignored
        vecs.push_back(mk(0, 1, 1, 1, 2'd3, 8'd0, 4'b0100, 2'd2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2'd3, 8'd0, 4'b1000, 2'd3, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2'd3, 8'd0, 4'b0001, 2'd0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2'd3, 8'd0, 4'b0010, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2'd3, 8'd0, 4'b0100, 2'd2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2'd3, 8'd0, 4'b1000, 2'd3, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2'd3, 8'd0, 4'b0001, 2'd0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2'd3, 8'd1, 4'b0001, 2'd0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 2'd2, 8'd1, 4'b0100, 2'd2, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 2'd2, 8'd1, 4'b0100, 2'd2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd2, 8'd1, 4'b0100, 2'd2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd2, 8'd1, 4'b1000, 2'd3, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd2, 8'd1, 4'b1000, 2'd3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2'd2, 8'd1, 4'b1000, 2'd3, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2'd2, 8'd1, 4'b1000, 2'd3, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 2'd1, 8'd1, 4'b0010, 2'd1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 2'd1, 8'd1, 4'b0010, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd1, 8'd1, 4'b0010, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd1, 8'd1, 4'b0100, 2'd2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 2'd1, 8'd1, 4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd1, 8'd1, 4'b0001, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd1, 8'd1, 4'b0001, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd1, 8'd1, 4'b0010, 2'd1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 2'd1, 8'd1, 4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd1, 8'd1, 4'b0001, 2'd0, 0, 0));

        foreach (vecs[i]) begin
            rst = vecs[i].r; en = vecs[i].e; mode = vecs[i].m;
            sel_valid = vecs[i].v; sel = vecs[i].s; dwell = vecs[i].d;
            step();
            compared++;
            if ({y, y_idx, wrap, sel_ready} !== {vecs[i].ey, vecs[i].ei, vecs[i].ew, vecs[i].er}) begin
                mismatched++;
                $display("FAIL vec%0d: got y=%b y_idx=%0d wrap=%b sel_ready=%b, expected y=%b y_idx=%0d wrap=%b sel_ready=%b",
                         i, y, y_idx, wrap, sel_ready, vecs[i].ey, vecs[i].ei, vecs[i].ew, vecs[i].er);
            end
        end

        // counter at 3 when dwell drops to 1: must wrap through 255 before the next advance
        dwell = 8'd3;
        sel_valid = 1'b0;
        repeat (3) step();
        check("dwell3_hold_y", int'(y), 1);
        dwell = 8'd1;
        n = 0;
        while (n < 300) begin
            step();
            n++;
            if (y != 4'b0001) break;
        end
        check("lowered_dwell_edges", n, 255);
        check("lowered_dwell_y", int'(y), 2);

        // full rotation between wrap pulses with dwell 3
        dwell = 8'd3;
        n = 0;
        while (!wrap && n < 100) begin
            step();
            n++;
        end
        check("wrap_seen", int'(wrap), 1);
        n = 0;
        do begin
            step();
            n++;
        end while (!wrap && n < 100);
        check("rotation_cycles", n, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered binary-to-one-hot decoder generalising the team's gate-level and dataflow 2:4 decoders to `2**SEL_W` outputs. It adds an enable, a valid/ready select handshake and an autonomous scan mode that rotates the active output with a programmable dwell time. It sits between control logic and any one-hot consumer: digit or row strobes, bank selects, chip selects.

## Interface
- `SEL_W`, default 2: select width; `OUT_W = 2**SEL_W` outputs (derived, not overridable).
- `DWELL_W`, default 8: dwell-count width.

- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: block enable; low forces all outputs off.
- `mode` input 1: 0 = direct decode, 1 = scan.
- `sel_valid` input 1: `sel` is valid.
- `sel_ready` output 1: block accepts `sel` this cycle.
- `sel` input SEL_W: binary index to decode.
- `dwell` input DWELL_W: scan hold time minus one.
- `y` output OUT_W: one-hot, or all-zero, output.
- `y_idx` output SEL_W: binary index of the current or last active output.
- `wrap` output 1: one-cycle pulse when the scan wraps to index 0.

## Operation
- **States:** IDLE, DIRECT, SCAN.
- **Reset:**
  - State goes to IDLE.
  - `y`=0, `y_idx`=0, `wrap`=0, `sel_ready`=0, dwell counter=0.
- **IDLE:**
  - `y`=0, `sel_ready`=0.
  - If `en`=1: go to DIRECT when `mode`=0, or SCAN when `mode`=1.
- **DIRECT:**
  - `sel_ready`=1.
  - On `sel_valid && sel_ready`: `y` <= `1<<sel` and `y_idx` <= `sel`.
  - Otherwise `y` holds its value. `y` stays 0 after entry from IDLE until the first accept.
- **SCAN:**
  - `sel_ready`=0; `sel_valid` is ignored.
  - `y` = `1<<y_idx`.
  - The dwell counter increments every cycle.
  - When counter == `dwell`: clear the counter and set `y_idx` <= `y_idx+1` modulo `OUT_W`.
  - `dwell` is compared live every cycle.
  - `dwell`=0 advances every cycle.
  - A counter value already above a newly lowered `dwell` still advances, when counter == `dwell` after wrapping modulo `2**DWELL_W`.
- **Wrap:** `wrap`=1 in exactly the cycle where `y` moves from bit `OUT_W-1` to bit 0. It is never asserted outside SCAN.
- **Entry from IDLE into SCAN:** `y_idx`=0, `y`=1, counter=0.
- **Mode change, SCAN→DIRECT:**
  - `y` and `y_idx` hold their values until the next accepted `sel`.
  - The counter clears.
- **Mode change, DIRECT→SCAN:**
  - Scanning starts from the current `y_idx` with the counter cleared.
  - `y` becomes `1<<y_idx` in the switch cycle +1.
- **`en` low:**
  - Takes effect in the next cycle regardless of `mode` or `sel_valid`.
  - `y`=0, `y_idx`=0, counter=0, `wrap`=0, state goes to IDLE.
- **Priority:** `rst` > `en`=0 > mode change > `sel` accept / scan advance.
- **Invariant:** `popcount(y)` ≤ 1 every cycle.

## Timing
- All outputs are registered. No combinational path from any input to `y`, `y_idx` or `wrap`.
- `sel_ready` is a registered function of state only.
- Direct decode: the accept at edge N makes `y` valid after edge N; observed by the consumer at edge N+1. Latency is 1 cycle.
- Scan: each output is high for exactly `dwell+1` cycles while `dwell` is constant.
- A full rotation takes `OUT_W*(dwell+1)` cycles.
- Reset or `en` dropping mid-scan clears state at that edge; there is no partial-rotation memory.
- Back-to-back accepts in DIRECT are permitted, one per cycle.

## Structure
- Shared package `decoder_pkg` holds:
  - the state enum (IDLE, DIRECT, SCAN);
  - a function `onehot(idx)` returning `1<<idx` for a given `SEL_W`.
- One natural sub-module: `dwell_counter`.
  - Load/clear input, `dwell` compare, `tick` output.
  - Used by the SCAN state.
- The decode itself is the package function, not a sub-module.

## Test plan
- SEL_W=2, reset held 2 cycles → `y`=0000, `y_idx`=0, `wrap`=0, `sel_ready`=0. After release with `en`=1, `mode`=0 → `sel_ready`=1 next cycle.
- DIRECT, `sel`=3, 2, 0, 1 back-to-back with valid → `y`=1000, 0100, 0001, 0010, each one cycle after its accept. Valid low → `y` holds 0010.
- SCAN with `dwell`=2 → `y` sequence 0001×3, 0010×3, 0100×3, 1000×3, 0001. `wrap`=1 only on the cycle `y` returns to 0001.
- SCAN with `dwell`=0 and `sel_valid`=1, `sel`=3 → `y` changes every cycle. `sel_ready`=0 and `sel` has no effect. `wrap` is high every 4th cycle.
- DIRECT `sel`=2 accepted, then `mode`→1 with `dwell`=1 → `y`=0100 for 2 cycles, then 1000. `mode`→0 mid-scan → `y` holds until the next accept.
- Mid-scan, `en`=0 for 1 cycle → `y`=0000 and `y_idx`=0 next cycle. With `en`=1 again → IDLE then SCAN, restarting at `y`=0001. `rst` asserted together with `en` gives the identical reset result.
